grc: RTL and testbench
======================

// Module: grc
// PURPOSE
//  Free-running N-bit Gray-code counter. It advances one code per rising clock edge.
//  Consecutive outputs differ in exactly one bit, so the count can cross clock
//  domains (e.g. FIFO pointers) or drive glitch-sensitive logic directly.
//  Standalone leaf block: no enable, no load, and no handshake.
// PARAMETERS
//  N  4  counter width in bits; legal range N >= 2; the count wraps modulo 2**N
// PORTS
//  clk   input   1  rising-edge clock; the only clock
//  rstn  input   1  asynchronous, active-low reset
//  out   output  N  current Gray-coded count, driven directly from a register
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-low.
//  - Reset:
//    - rstn=0 clears the internal binary count bin[N-1:0] and out to 0 immediately,
//      without waiting for a clock edge.
//    - Both stay 0 while rstn=0, including across clock edges.
//  - Reset release:
//    - Deassertion is sampled at clock edges.
//    - An edge where rstn is still 0 does not count.
//    - The first posedge that samples rstn=1 produces out=1.
//  - Each posedge with rstn=1 does:
//    - bin <= bin + 1 (modulo 2**N)
//    - out <= (bin+1) ^ ((bin+1) >> 1)
//    - So out always equals gray(bin) with zero extra latency. There are no
//      combinational paths to out.
//  - N=4 sequence from reset (hex):
//    0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0 again. Period = 16 clocks.
//  - Wrap: bin 2**N-1 -> 0, and out goes from 1000..0 to 0. This is still a
//    single-bit change.
//  - Invariant: popcount(out_prev ^ out_next) == 1 on every counting edge.
//  - Reset mid-count: out returns to 0 asynchronously. Counting resumes from 1
//    on the first edge after release.
//  - No X propagation: all state is reset. Width arithmetic is unsigned N-bit,
//    and the carry out is discarded.
// STRUCTURE
//  - No shared package is needed. N is the only constant.
//  - One sub-module: grc_bin2gray.
//    - Parameter N. Ports bin_i[N-1:0] -> gray_o[N-1:0].
//    - Purely combinational: gray_o = bin_i ^ (bin_i >> 1).
//  - Top level: binary incrementer + grc_bin2gray on the next-count value + the
//    out register + the bin register. Both registers use async-clear on rstn.
//  - Optional: a companion gray2bin function for verification use only.
// TESTING
//  1. Hold rstn=0 for 2 clocks -> out=0 throughout; the clock does not advance it.
//  2. Release rstn; run 20 clocks -> out = 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1,3,2,6.
//  3. Checker on every counting edge -> exactly one bit of out toggles, including
//     at the 8 -> 0 wrap.
//  4. Assert rstn=0 between edges while out=D -> out=0 before the next posedge;
//     after release the next value is 1.
//  5. N=5, run 32 clocks -> visits all 32 codes once, returns to 0, each step
//     a 1-bit change.
//  6. gray2bin(out) on each edge -> equals a reference binary counter that
//     increments by 1.

Source files
------------

// File: rtl/grc_pkg.sv
// ============================================================================
// Module      : grc_pkg
// Description : Shared constants for the Gray-code counter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package grc_pkg;
  localparam int GRC_DEFAULT_N = 4;
endpackage

`default_nettype wire

// File: rtl/grc_bin2gray.sv
// ============================================================================
// Module      : grc_bin2gray
// Description : Combinational binary-to-Gray converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grc_bin2gray
  import grc_pkg::*;
#(
  parameter int N = GRC_DEFAULT_N
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

`default_nettype wire

// File: rtl/grc.sv
// ============================================================================
// Module      : grc
// Description : Free-running N-bit Gray-code counter with registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grc
  import grc_pkg::*;
#(
  parameter int N = GRC_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rstn,
  output logic [N-1:0] out
);

  localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_bin;
  logic [N-1:0] r_out;
  logic [N-1:0] w_bin_next;
  logic [N-1:0] w_gray_next;

  // Carry out of the top bit is discarded, giving the modulo-2**N wrap.
  assign w_bin_next = r_bin + c_one;

  // Converting the next count keeps out a pure register with no output logic.
  grc_bin2gray #(
    .N (N)
  ) u_bin2gray (
    .bin_i  (w_bin_next),
    .gray_o (w_gray_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bin <= '0;
      r_out <= '0;
    end else begin
      r_bin <= w_bin_next;
      r_out <= w_gray_next;
    end
  end

  assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_grc.sv
// Bench for grc: N=4 and N=5 instances against an integer-count Gray model.
`default_nettype none

module tb_grc;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] out4;
  logic [4:0] out5;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cnt;
  logic [3:0]  prev4;
  logic [4:0]  prev5;
  bit          prev_ok;
  logic [31:0] seen;
  logic [3:0]  tbl [20];

  grc #(.N(4)) u_dut4 (.clk(clk), .rstn(rstn), .out(out4));
  grc #(.N(5)) u_dut5 (.clk(clk), .rstn(rstn), .out(out5));

  always #5 clk = ~clk;

  function automatic logic [31:0] gray(input int unsigned x);
    return 32'(x ^ (x >> 1));
  endfunction

  // Prefix-XOR from the MSB down recovers the binary value.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] r;
    r = g;
    for (int s = 1; s < 32; s = s * 2) r = r ^ (r >> s);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic restart_model();
    cnt     = 0;
    prev4   = '0;
    prev5   = '0;
    prev_ok = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cnt++;
    check("seq4", 32'(out4), gray(cnt % 16));
    check("seq5", 32'(out5), gray(cnt % 32));
    check("g2b4", gray2bin(32'(out4)), 32'(cnt % 16));
    check("g2b5", gray2bin(32'(out5)), 32'(cnt % 32));
    if (prev_ok) begin
      check("onebit4", 32'($countones(prev4 ^ out4)), 32'd1);
      check("onebit5", 32'($countones(prev5 ^ out5)), 32'd1);
    end
    prev4   = out4;
    prev5   = out5;
    prev_ok = 1'b1;
  endtask

  initial begin
    tbl = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD, 4'hF,
            4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1, 4'h3, 4'h2, 4'h6};
    prev_ok = 1'b0;
    cnt     = 0;

    // Reset asserted before any clock edge must clear immediately.
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("rst_async4", 32'(out4), 32'd0);
    check("rst_async5", 32'(out5), 32'd0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_hold4", 32'(out4), 32'd0);
      check("rst_hold5", 32'(out5), 32'd0);
    end

    rstn = 1'b1;
    restart_model();
    for (int i = 0; i < 20; i++) begin
      step();
      check("table4", 32'(out4), 32'(tbl[i]));
    end

    // Mid-count asynchronous reset while out4 shows D.
    for (int k = 0; k < 40 && out4 != 4'hD; k++) step();
    check("reach_d", 32'(out4), 32'hD);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst4", 32'(out4), 32'd0);
    check("mid_rst5", 32'(out5), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_hold4", 32'(out4), 32'd0);
    rstn = 1'b1;
    restart_model();
    step();
    check("resume4", 32'(out4), 32'd1);

    // Full N=5 period: every code once, ending back at 0.
    seen = '0;
    seen[out5] = 1'b1;
    for (int i = 0; i < 31; i++) begin
      step();
      seen[out5] = 1'b1;
    end
    check("allcodes5", seen, 32'hFFFF_FFFF);
    check("wrap5", 32'(out5), 32'd0);

    // Random run lengths with asynchronous resets at random points mid-cycle.
    repeat (6) begin
      int unsigned len;
      len = $urandom_range(1, 40);
      repeat (len) step();
      #($urandom_range(1, 3)) rstn = 1'b0;
      #1;
      check("rnd_rst4", 32'(out4), 32'd0);
      check("rnd_rst5", 32'(out5), 32'd0);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      @(negedge clk);
      check("rnd_hold5", 32'(out5), 32'd0);
      rstn = 1'b1;
      restart_model();
    end
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
